// File: rtl/rps_pkg.sv
// Shared round-result codes and scorer FSM encoding; also used by the game
// logic that produces the winner code.
package rps_pkg;

  typedef enum logic [1:0] {
    WIN_PLAYER   = 2'b00,
    WIN_COMPUTER = 2'b01,
    WIN_NONE     = 2'b10,
    WIN_DRAW     = 2'b11
  } winner_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_OVER = 2'b10
  } state_e;

endpackage

// File: rtl/rps_sat_counter.sv
// Up-counter that sticks at LIMIT; clr and clear_b both return it to zero.
module rps_sat_counter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned LIMIT = 15
) (
  input  logic             clk,
  input  logic             clear_b,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

  always_ff @(posedge clk) begin
    if (!clear_b) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != LIM)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/rps_match_scorer.sv
// Rock-paper-scissors match scorekeeper: counts round results and ends the
// match when either side reaches WINS_NEEDED round wins.
module rps_match_scorer
  import rps_pkg::*;
#(
  parameter int unsigned WINS_NEEDED = 3
) (
  input  logic       clk,
  input  logic       clear_b,
  input  logic       new_match,
  input  logic       round_valid,
  input  logic [1:0] winner,
  output logic [1:0] player_score,
  output logic [1:0] computer_score,
  output logic [3:0] draw_count,
  output logic [3:0] round_num,
  output logic [1:0] last_result,
  output logic       round_ack,
  output logic       bad_code,
  output logic       match_over,
  output logic [1:0] match_winner
);

  localparam logic [1:0] WIN_LAST = 2'(WINS_NEEDED - 1);

  state_e state, next_state;
  logic   accept, illegal;
  logic   inc_player, inc_computer, inc_draw;

  // new_match outranks a same-cycle strobe, so a round is only seen when it is low
  always_comb begin
    accept       = 1'b0;
    illegal      = 1'b0;
    inc_player   = 1'b0;
    inc_computer = 1'b0;
    inc_draw     = 1'b0;
    next_state   = state;

    if (state == ST_PLAY && round_valid && !new_match) begin
      illegal      = (winner == WIN_NONE);
      accept       = !illegal;
      inc_player   = (winner == WIN_PLAYER);
      inc_computer = (winner == WIN_COMPUTER);
      inc_draw     = (winner == WIN_DRAW);
    end

    if (new_match) begin
      next_state = ST_PLAY;
    end else if ((inc_player && player_score == WIN_LAST) ||
                 (inc_computer && computer_score == WIN_LAST)) begin
      next_state = ST_OVER;
    end
  end

  always_ff @(posedge clk) begin
    if (!clear_b) begin
      state       <= ST_IDLE;
      last_result <= WIN_NONE;
      round_ack   <= 1'b0;
      bad_code    <= 1'b0;
    end else begin
      state     <= next_state;
      round_ack <= accept;
      bad_code  <= illegal;
      if (new_match) begin
        last_result <= WIN_NONE;
      end else if (accept) begin
        last_result <= winner;
      end
    end
  end

  rps_sat_counter #(.WIDTH(2), .LIMIT(WINS_NEEDED)) u_player_cnt (
    .clk(clk), .clear_b(clear_b), .clr(new_match), .en(inc_player), .count(player_score)
  );

  rps_sat_counter #(.WIDTH(2), .LIMIT(WINS_NEEDED)) u_computer_cnt (
    .clk(clk), .clear_b(clear_b), .clr(new_match), .en(inc_computer), .count(computer_score)
  );

  rps_sat_counter #(.WIDTH(4), .LIMIT(15)) u_draw_cnt (
    .clk(clk), .clear_b(clear_b), .clr(new_match), .en(inc_draw), .count(draw_count)
  );

  rps_sat_counter #(.WIDTH(4), .LIMIT(15)) u_round_cnt (
    .clk(clk), .clear_b(clear_b), .clr(new_match), .en(accept), .count(round_num)
  );

  // Winner is derived from registered state and scores, so it appears on the ending edge
  always_comb begin
    match_over   = (state == ST_OVER);
    match_winner = WIN_DRAW;
    if (state == ST_OVER) begin
      match_winner = (player_score == 2'(WINS_NEEDED)) ? WIN_PLAYER : WIN_COMPUTER;
    end
  end

endmodule
